// File: rtl/door_pkg.sv
// Shared constants and signal bundles for the door_1315 input path.
package door_pkg;

    localparam int unsigned DEBOUNCE_DEFAULT = 4;

    localparam logic LB_RST_VAL  = 1'b1;
    localparam logic LVL_RST_VAL = 1'b0;

    typedef struct packed {
        logic up;
        logic down;
        logic top;
        logic bottom;
        logic lb;
    } door_raw_t;

    typedef struct packed {
        logic buttonup;
        logic buttondown;
        logic sensortop;
        logic sensorbottom;
        logic lightbarrier;
        logic sensorfault;
    } door_cond_t;

endpackage

// File: rtl/debounce_channel.sv
// Two-flop synchroniser followed by a counting debouncer for one raw input.
module debounce_channel import door_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter logic        RST_VAL         = LVL_RST_VAL,
    parameter bit          FAST_ASSERT     = 1'b0,
    localparam int unsigned CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic lvl_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= RST_VAL;
            s2_q  <= RST_VAL;
            lvl_q <= RST_VAL;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (s2_q == lvl_q) begin
            cnt_d = '0;
        end else if (FAST_ASSERT && s2_q) begin
            // Obstruction is safety-relevant: take it without debounce delay.
            lvl_d = 1'b1;
        end else if (cnt_q == CntLast) begin
            lvl_d = s2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign lvl_o = lvl_q;

endmodule

// File: rtl/door_input_conditioner.sv
// Conditions raw door buttons/sensors into clean door_1315 inputs:
// debounced levels, single-cycle button pulses and an end-sensor fault flag.
module door_input_conditioner import door_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic buttonup_raw,
    input  logic buttondown_raw,
    input  logic sensortop_raw,
    input  logic sensorbottom_raw,
    input  logic lightbarrier_raw,
    output logic buttonup,
    output logic buttondown,
    output logic sensortop,
    output logic sensorbottom,
    output logic lightbarrier,
    output logic sensorfault
);

    door_raw_t  raw;
    door_raw_t  lvl;
    door_cond_t cond;

    logic up_prev_q, dn_prev_q;
    logic up_pulse_q, up_pulse_d;
    logic dn_pulse_q, dn_pulse_d;
    logic fault_q, fault_d;

    assign raw = '{
        up:     buttonup_raw,
        down:   buttondown_raw,
        top:    sensortop_raw,
        bottom: sensorbottom_raw,
        lb:     lightbarrier_raw
    };

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (LVL_RST_VAL),
        .FAST_ASSERT    (1'b0)
    ) u_up (
        .clk  (clk),
        .rst  (rst),
        .raw_i(raw.up),
        .lvl_o(lvl.up)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (LVL_RST_VAL),
        .FAST_ASSERT    (1'b0)
    ) u_down (
        .clk  (clk),
        .rst  (rst),
        .raw_i(raw.down),
        .lvl_o(lvl.down)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (LVL_RST_VAL),
        .FAST_ASSERT    (1'b0)
    ) u_top (
        .clk  (clk),
        .rst  (rst),
        .raw_i(raw.top),
        .lvl_o(lvl.top)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (LVL_RST_VAL),
        .FAST_ASSERT    (1'b0)
    ) u_bottom (
        .clk  (clk),
        .rst  (rst),
        .raw_i(raw.bottom),
        .lvl_o(lvl.bottom)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (LB_RST_VAL),
        .FAST_ASSERT    (1'b1)
    ) u_lb (
        .clk  (clk),
        .rst  (rst),
        .raw_i(raw.lb),
        .lvl_o(lvl.lb)
    );

    // A high opposite level also covers the case where it rose in this same cycle.
    always_comb begin
        up_pulse_d = lvl.up & ~up_prev_q & ~lvl.down;
        dn_pulse_d = lvl.down & ~dn_prev_q & ~lvl.up;
        fault_d    = lvl.top & lvl.bottom;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_prev_q  <= LVL_RST_VAL;
            dn_prev_q  <= LVL_RST_VAL;
            up_pulse_q <= 1'b0;
            dn_pulse_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            up_prev_q  <= lvl.up;
            dn_prev_q  <= lvl.down;
            up_pulse_q <= up_pulse_d;
            dn_pulse_q <= dn_pulse_d;
            fault_q    <= fault_d;
        end
    end

    assign cond = '{
        buttonup:     up_pulse_q,
        buttondown:   dn_pulse_q,
        sensortop:    lvl.top,
        sensorbottom: lvl.bottom,
        lightbarrier: lvl.lb,
        sensorfault:  fault_q
    };

    assign buttonup     = cond.buttonup;
    assign buttondown   = cond.buttondown;
    assign sensortop    = cond.sensortop;
    assign sensorbottom = cond.sensorbottom;
    assign lightbarrier = cond.lightbarrier;
    assign sensorfault  = cond.sensorfault;

endmodule

// File: tb/tb_door_input_conditioner.sv
// Scoreboard bench for door_input_conditioner with DEBOUNCE_CYCLES = 4.
`timescale 1ns/1ps
module tb_door_input_conditioner;

    localparam int B_UP  = 0;
    localparam int B_DN  = 1;
    localparam int B_TOP = 2;
    localparam int B_BOT = 3;
    localparam int B_LB  = 4;
    localparam int B_FLT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up_raw = 1'b0, dn_raw = 1'b0, top_raw = 1'b0, bot_raw = 1'b0, lb_raw = 1'b0;
    logic buttonup, buttondown, sensortop, sensorbottom, lightbarrier, sensorfault;
    logic [5:0] obs;

    typedef struct {
        int    cyc;
        int    idx;
        logic  val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   up_cnt = 0;
    int   dn_cnt = 0;

    always #5 clk = ~clk;

    door_input_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .buttonup_raw    (up_raw),
        .buttondown_raw  (dn_raw),
        .sensortop_raw   (top_raw),
        .sensorbottom_raw(bot_raw),
        .lightbarrier_raw(lb_raw),
        .buttonup        (buttonup),
        .buttondown      (buttondown),
        .sensortop       (sensortop),
        .sensorbottom    (sensorbottom),
        .lightbarrier    (lightbarrier),
        .sensorfault     (sensorfault)
    );

    assign obs = {sensorfault, lightbarrier, sensorbottom, sensortop, buttondown, buttonup};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expect output bit idx to equal val at the negedge following edge cyc+dly.
    task automatic expect_bit(input int dly, input int idx, input logic val, input string tag);
        exp_t e;
        e.cyc = cyc + dly;
        e.idx = idx;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        expect_bit(1, B_LB, 1'b1, "lb_hold_e1");
        expect_bit(4, B_LB, 1'b1, "lb_hold_e4");
        expect_bit(6, B_LB, 1'b0, "lb_clear_e6");
        expect_bit(6, B_TOP, 1'b0, "top_after_rst");
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && buttonup)   up_cnt++;
        if (!rst && buttondown) dn_cnt++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_eq(sb[i].tag, int'(obs[sb[i].idx]), int'(sb[i].val));
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                check_eq({sb[i].tag, "_missed"}, 0, 1);
                sb.delete(i);
            end
        end
    end

    initial begin
        int base_up;
        int base_dn;

        tick(3);
        release_reset();
        tick(12);

        // Light barrier: fast assert, dip rejection, debounced release
        lb_raw = 1'b1;
        expect_bit(2, B_LB, 1'b0, "lb_pre_assert");
        expect_bit(3, B_LB, 1'b1, "lb_fast_assert");
        tick(6);
        lb_raw = 1'b0;
        tick(1);
        lb_raw = 1'b1;
        expect_bit(2, B_LB, 1'b1, "lb_dip_a");
        expect_bit(5, B_LB, 1'b1, "lb_dip_b");
        expect_bit(8, B_LB, 1'b1, "lb_dip_c");
        tick(10);
        lb_raw = 1'b0;
        expect_bit(5, B_LB, 1'b1, "lb_deb_hold");
        expect_bit(6, B_LB, 1'b0, "lb_deb_clear");
        tick(10);

        // Glitch rejection and accepted pulse on sensortop
        top_raw = 1'b1;
        tick(3);
        top_raw = 1'b0;
        expect_bit(3, B_TOP, 1'b0, "glitch3_a");
        expect_bit(5, B_TOP, 1'b0, "glitch3_b");
        expect_bit(8, B_TOP, 1'b0, "glitch3_c");
        tick(10);
        top_raw = 1'b1;
        expect_bit(5, B_TOP, 1'b0, "top_rise_pre");
        expect_bit(6, B_TOP, 1'b1, "top_rise");
        tick(5);
        top_raw = 1'b0;
        expect_bit(5, B_TOP, 1'b1, "top_fall_pre");
        expect_bit(6, B_TOP, 1'b0, "top_fall");
        expect_bit(6, B_FLT, 1'b0, "no_fault_single");
        tick(10);

        // Single press, then a second press
        base_up = up_cnt;
        base_dn = dn_cnt;
        dn_raw = 1'b1;
        expect_bit(6, B_DN, 1'b0, "dn_pulse_pre");
        expect_bit(7, B_DN, 1'b1, "dn_pulse");
        expect_bit(8, B_DN, 1'b0, "dn_pulse_end");
        tick(20);
        dn_raw = 1'b0;
        tick(10);
        check_eq("press1_dn_count", dn_cnt - base_dn, 1);
        check_eq("press1_up_count", up_cnt - base_up, 0);
        base_dn = dn_cnt;
        dn_raw = 1'b1;
        expect_bit(7, B_DN, 1'b1, "dn_pulse2");
        tick(10);
        dn_raw = 1'b0;
        tick(10);
        check_eq("press2_dn_count", dn_cnt - base_dn, 1);

        // Conflicts
        base_up = up_cnt;
        base_dn = dn_cnt;
        up_raw = 1'b1;
        dn_raw = 1'b1;
        tick(20);
        up_raw = 1'b0;
        dn_raw = 1'b0;
        tick(10);
        check_eq("both_up_count", up_cnt - base_up, 0);
        check_eq("both_dn_count", dn_cnt - base_dn, 0);
        base_up = up_cnt;
        base_dn = dn_cnt;
        up_raw = 1'b1;
        expect_bit(7, B_UP, 1'b1, "up_pulse");
        tick(10);
        dn_raw = 1'b1;
        tick(10);
        up_raw = 1'b0;
        dn_raw = 1'b0;
        tick(10);
        check_eq("held_up_count", up_cnt - base_up, 1);
        check_eq("held_dn_count", dn_cnt - base_dn, 0);

        // Sensor fault set and clear
        top_raw = 1'b1;
        tick(2);
        bot_raw = 1'b1;
        expect_bit(6, B_FLT, 1'b0, "fault_pre");
        expect_bit(7, B_FLT, 1'b1, "fault_set");
        tick(12);
        top_raw = 1'b0;
        expect_bit(5, B_FLT, 1'b1, "fault_hold");
        expect_bit(6, B_TOP, 1'b0, "fault_top_drop");
        expect_bit(6, B_FLT, 1'b1, "fault_hold2");
        expect_bit(7, B_FLT, 1'b0, "fault_clear");
        tick(10);
        top_raw = 1'b1;
        tick(10);

        // Asynchronous reset mid-count
        check_eq("pre_rst_outputs", int'(obs), 32'h2C);
        base_up = up_cnt;
        up_raw = 1'b1;
        tick(2);
        #2 rst = 1'b1;
        #1 check_eq("rst_async_outputs", int'(obs), 32'h10);
        up_raw  = 1'b0;
        top_raw = 1'b0;
        bot_raw = 1'b0;
        tick(3);
        release_reset();
        tick(15);
        check_eq("post_rst_up_count", up_cnt - base_up, 0);

        tick(2);
        check_eq("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
